// File: rtl/buffer_ring_manager.sv
// -----------------------------------------------------------------------------
// buffer_ring_manager
//
// Manages a ring of NUM_BUFFERS equal frame buffers in DDR for the S2MM
// capture path. A single writer fills frames word by word. The reader claims
// the most recently completed frame with a request edge. The block also keeps
// a wrapping frame counter and a saturating count of frames that were
// overwritten before anyone claimed them.
//
// Ports
//   aclk             system clock
//   areset           synchronous active-high reset
//   SM_enable        1 = capture running; 0 = write progress frozen and cleared
//   SM_log_length    log2 of frame length in words (clamped to MAX_LOG_LENGTH)
//   SM_base_address  byte address of buffer 0
//   SM_writing       one pulse per word accepted by the writer
//   SM_request       reader claim request, rising edge significant
//   SM_read_buffer   base address of the buffer held by the reader
//   SM_write_buffer  address of the next word to write
//   SM_ready_valid   a completed, unclaimed frame exists
//   SM_ack           one-cycle pulse when a claim is served
//   SM_frame_count   completed frames, wraps
//   SM_drop_count    frames overwritten unclaimed, saturates
// -----------------------------------------------------------------------------
module buffer_ring_manager #(
    parameter int MM_ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_BUFFERS    = 4,
    parameter int MAX_LOG_LENGTH = 22,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     SM_enable,
    input  logic [4:0]               SM_log_length,
    input  logic [MM_ADDR_WIDTH-1:0] SM_base_address,
    input  logic                     SM_writing,
    input  logic                     SM_request,
    output logic [MM_ADDR_WIDTH-1:0] SM_read_buffer,
    output logic [MM_ADDR_WIDTH-1:0] SM_write_buffer,
    output logic                     SM_ready_valid,
    output logic                     SM_ack,
    output logic [COUNT_WIDTH-1:0]   SM_frame_count,
    output logic [COUNT_WIDTH-1:0]   SM_drop_count
);

    localparam int IDX_W = $clog2(NUM_BUFFERS);
    // Word counter only needs to reach 2**MAX_LOG_LENGTH - 1.
    localparam int CNT_W = (MAX_LOG_LENGTH > 0) ? MAX_LOG_LENGTH : 1;
    localparam logic [4:0]               MAX_LEN    = 5'(MAX_LOG_LENGTH);
    localparam logic [MM_ADDR_WIDTH-1:0] WORD_BYTES = MM_ADDR_WIDTH'(DATA_WIDTH / 8);

    // Lowest buffer index that is neither a nor b. Pass the same index twice
    // to exclude only one buffer.
    function automatic logic [IDX_W-1:0] pick_free(input logic [IDX_W-1:0] a,
                                                   input logic [IDX_W-1:0] b);
        // NOTE: the result gets a default before the loop so every path
        // assigns it; combinational code without a default infers a latch.
        pick_free = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (IDX_W'(i) != a && IDX_W'(i) != b) begin
                pick_free = IDX_W'(i);
            end
        end
    endfunction

    logic [IDX_W-1:0]       r_read_idx;
    logic [IDX_W-1:0]       r_ready_idx;
    logic [IDX_W-1:0]       r_write_idx;
    logic                   r_ready_valid;
    logic [CNT_W-1:0]       r_write_count;
    logic [4:0]             r_len_log;
    logic                   r_req_d;
    logic                   r_ack;
    logic [COUNT_WIDTH-1:0] r_frame_count;
    logic [COUNT_WIDTH-1:0] r_drop_count;

    logic [4:0]               w_len_sat;
    logic [CNT_W-1:0]         w_last;
    logic [MM_ADDR_WIDTH-1:0] w_stride;
    logic                     w_write;
    logic                     w_complete;
    logic                     w_req_edge;

    assign w_len_sat  = (SM_log_length > MAX_LEN) ? MAX_LEN : SM_log_length;
    // When len_log equals CNT_W the shift wraps to zero and the subtraction
    // yields all-ones, which is exactly the last word index.
    assign w_last     = (CNT_W'(1) << r_len_log) - CNT_W'(1);
    assign w_stride   = WORD_BYTES << r_len_log;
    assign w_write    = SM_enable & SM_writing;
    assign w_complete = w_write && (r_write_count == w_last);
    assign w_req_edge = SM_request & ~r_req_d;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_read_idx    <= '0;
            r_ready_idx   <= '0;
            r_write_idx   <= IDX_W'(1);
            r_ready_valid <= 1'b0;
            r_write_count <= '0;
            r_len_log     <= w_len_sat;
            r_req_d       <= 1'b0;
            r_ack         <= 1'b0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below sees the pre-edge values of the indices.
            r_req_d <= SM_request;
            r_ack   <= 1'b0;

            if (!SM_enable) begin
                r_write_count <= '0;
                r_len_log     <= w_len_sat;
            end else if (w_write) begin
                if (w_complete) begin
                    r_write_count <= '0;
                    r_len_log     <= w_len_sat;
                end else begin
                    r_write_count <= r_write_count + CNT_W'(1);
                end
            end

            if (w_complete) begin
                r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
                r_ready_idx   <= r_write_idx;
                if (w_req_edge) begin
                    // Reader takes the frame finishing this cycle; any older
                    // ready frame is superseded rather than lost.
                    r_read_idx    <= r_write_idx;
                    r_ready_valid <= 1'b0;
                    r_write_idx   <= pick_free(r_write_idx, r_write_idx);
                    r_ack         <= 1'b1;
                end else begin
                    r_ready_valid <= 1'b1;
                    r_write_idx   <= pick_free(r_read_idx, r_write_idx);
                    if (r_ready_valid && (r_drop_count != '1)) begin
                        r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
                    end
                end
            end else if (w_req_edge && r_ready_valid) begin
                r_read_idx    <= r_ready_idx;
                r_ready_valid <= 1'b0;
                r_ack         <= 1'b1;
            end
        end
    end

    assign SM_read_buffer  = SM_base_address + MM_ADDR_WIDTH'(r_read_idx) * w_stride;
    assign SM_write_buffer = SM_base_address + MM_ADDR_WIDTH'(r_write_idx) * w_stride
                           + MM_ADDR_WIDTH'(r_write_count) * WORD_BYTES;
    assign SM_ready_valid  = r_ready_valid;
    assign SM_ack          = r_ack;
    assign SM_frame_count  = r_frame_count;
    assign SM_drop_count   = r_drop_count;

endmodule

// File: tb/tb_buffer_ring_manager.sv
// -----------------------------------------------------------------------------
// tb_buffer_ring_manager
//
// Self-checking bench for buffer_ring_manager with NUM_BUFFERS=4 and a
// 0x1000_0000 base. A vector table drives a long reader/writer scenario whose
// expected outputs go through a scoreboard queue; hand sequences cover
// overwrite, simultaneous claim/completion, mid-frame changes and length
// clamping. Buffer index invariants are watched every cycle.
// -----------------------------------------------------------------------------
module tb_buffer_ring_manager;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        aclk = 1'b0;
    logic        areset;
    logic        SM_enable;
    logic [4:0]  SM_log_length;
    logic [31:0] SM_base_address;
    logic        SM_writing;
    logic        SM_request;
    logic [31:0] SM_read_buffer;
    logic [31:0] SM_write_buffer;
    logic        SM_ready_valid;
    logic        SM_ack;
    logic [15:0] SM_frame_count;
    logic [15:0] SM_drop_count;

    buffer_ring_manager #(
        .MM_ADDR_WIDTH (32),
        .DATA_WIDTH    (32),
        .NUM_BUFFERS   (4),
        .MAX_LOG_LENGTH(22),
        .COUNT_WIDTH   (16)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .SM_enable      (SM_enable),
        .SM_log_length  (SM_log_length),
        .SM_base_address(SM_base_address),
        .SM_writing     (SM_writing),
        .SM_request     (SM_request),
        .SM_read_buffer (SM_read_buffer),
        .SM_write_buffer(SM_write_buffer),
        .SM_ready_valid (SM_ready_valid),
        .SM_ack         (SM_ack),
        .SM_frame_count (SM_frame_count),
        .SM_drop_count  (SM_drop_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] w;
        logic [31:0] r;
        logic        rv;
        logic        ack;
        logic [15:0] fc;
        logic [15:0] dc;
    } exp_t;

    typedef struct {
        logic en;
        logic wr;
        logic req;
        exp_t e;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [31:0] w, input logic [31:0] r, input logic rv,
                                input logic ack, input logic [15:0] fc, input logic [15:0] dc);
        exp_t e;
        e.w = w; e.r = r; e.rv = rv; e.ack = ack; e.fc = fc; e.dc = dc;
        return e;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, ".write_buffer"}, SM_write_buffer, e.w);
        check({tag, ".read_buffer"},  SM_read_buffer,  e.r);
        check({tag, ".ready_valid"},  SM_ready_valid,  e.rv);
        check({tag, ".ack"},          SM_ack,          e.ack);
        check({tag, ".frame_count"},  SM_frame_count,  e.fc);
        check({tag, ".drop_count"},   SM_drop_count,   e.dc);
    endtask

    // Outputs are sampled 1 ns after the active edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] lg);
        SM_log_length = lg;
        SM_enable     = 1'b1;
        SM_writing    = 1'b0;
        SM_request    = 1'b0;
        areset        = 1'b1;
        step();
        areset        = 1'b0;
    endtask

    task automatic pulses(input int n);
        SM_writing = 1'b1;
        repeat (n) step();
        SM_writing = 1'b0;
    endtask

    // Continuous buffer-ownership invariant.
    always @(negedge aclk) begin
        if (areset === 1'b0) begin
            if (dut.r_write_idx == dut.r_read_idx ||
                (dut.r_ready_valid && dut.r_write_idx == dut.r_ready_idx)) begin
                n_checks++;
                $display("FAIL invariant: write_idx=%0d read_idx=%0d ready_idx=%0d ready_valid=%0b, expected write_idx distinct",
                         dut.r_write_idx, dut.r_read_idx, dut.r_ready_idx, dut.r_ready_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        SM_base_address = BASE;
        areset          = 1'b1;
        SM_enable       = 1'b1;
        SM_writing      = 1'b0;
        SM_request      = 1'b0;
        SM_log_length   = 5'd2;

        // Scenario table: {en, wr, req, {write_buf, read_buf, rv, ack, fc, dc}}.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, mk(BASE + 32'h14, BASE,         1'b0, 1'b0, 16'd0, 16'd0)};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, mk(BASE + 32'h18, BASE,         1'b0, 1'b0, 16'd0, 16'd0)};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, mk(BASE + 32'h1C, BASE,         1'b0, 1'b0, 16'd0, 16'd0)};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, mk(BASE + 32'h20, BASE,         1'b1, 1'b0, 16'd1, 16'd0)};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, mk(BASE + 32'h20, BASE + 32'h10, 1'b0, 1'b1, 16'd1, 16'd0)};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, mk(BASE + 32'h20, BASE + 32'h10, 1'b0, 1'b0, 16'd1, 16'd0)};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, mk(BASE + 32'h20, BASE + 32'h10, 1'b0, 1'b0, 16'd1, 16'd0)};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, mk(BASE + 32'h24, BASE + 32'h10, 1'b0, 1'b0, 16'd1, 16'd0)};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, mk(BASE + 32'h28, BASE + 32'h10, 1'b0, 1'b0, 16'd1, 16'd0)};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, mk(BASE + 32'h2C, BASE + 32'h10, 1'b0, 1'b0, 16'd1, 16'd0)};
        vecs[10] = '{1'b1, 1'b1, 1'b0, mk(BASE,          BASE + 32'h10, 1'b1, 1'b0, 16'd2, 16'd0)};
        vecs[11] = '{1'b1, 1'b1, 1'b0, mk(BASE + 32'h04, BASE + 32'h10, 1'b1, 1'b0, 16'd2, 16'd0)};
        vecs[12] = '{1'b1, 1'b1, 1'b1, mk(BASE + 32'h08, BASE + 32'h20, 1'b0, 1'b1, 16'd2, 16'd0)};
        vecs[13] = '{1'b1, 1'b0, 1'b0, mk(BASE + 32'h08, BASE + 32'h20, 1'b0, 1'b0, 16'd2, 16'd0)};
        vecs[14] = '{1'b0, 1'b1, 1'b0, mk(BASE,          BASE + 32'h20, 1'b0, 1'b0, 16'd2, 16'd0)};
        vecs[15] = '{1'b1, 1'b0, 1'b0, mk(BASE,          BASE + 32'h20, 1'b0, 1'b0, 16'd2, 16'd0)};

        // Reset values.
        do_reset(5'd2);
        check_outs("reset", mk(BASE + 32'h10, BASE, 1'b0, 1'b0, 16'd0, 16'd0));

        // Table-driven scenario through the scoreboard.
        for (int i = 0; i < 16; i++) begin
            SM_enable  = vecs[i].en;
            SM_writing = vecs[i].wr;
            SM_request = vecs[i].req;
            exp_q.push_back(vecs[i].e);
            step();
            e = exp_q.pop_front();
            check_outs($sformatf("vec%0d", i), e);
        end
        SM_enable  = 1'b1;
        SM_writing = 1'b0;
        SM_request = 1'b0;

        // Overwrite: two frames with no claim drop the first.
        do_reset(5'd2);
        pulses(8);
        check("ovr.frame_count", SM_frame_count, 16'd2);
        check("ovr.drop_count",  SM_drop_count,  16'd1);
        check("ovr.ready_valid", SM_ready_valid, 1'b1);
        check("ovr.read_buffer", SM_read_buffer, BASE);
        SM_request = 1'b1;
        step();
        SM_request = 1'b0;
        check("ovr.claim_read",  SM_read_buffer, BASE + 32'h20);
        check("ovr.claim_ack",   SM_ack,         1'b1);

        // Claim edge on the same cycle as a completion with a frame ready.
        do_reset(5'd2);
        pulses(7);
        check("sim.pre_ready_valid", SM_ready_valid, 1'b1);
        SM_writing = 1'b1;
        SM_request = 1'b1;
        step();
        SM_writing = 1'b0;
        SM_request = 1'b0;
        check_outs("sim", mk(BASE, BASE + 32'h20, 1'b0, 1'b1, 16'd2, 16'd0));
        step();
        check("sim.ack_clear", SM_ack, 1'b0);

        // Length change mid-frame takes effect only at completion.
        do_reset(5'd2);
        pulses(2);
        SM_log_length = 5'd3;
        pulses(1);
        check("len.mid_write",   SM_write_buffer, BASE + 32'h1C);
        check("len.mid_frames",  SM_frame_count,  16'd0);
        pulses(1);
        check("len.done_frames", SM_frame_count,  16'd1);
        check("len.new_stride",  SM_write_buffer, BASE + 32'h40);
        SM_log_length = 5'd2;

        // Reset mid-frame with a writer pulse present.
        do_reset(5'd2);
        pulses(6);
        areset     = 1'b1;
        SM_writing = 1'b1;
        step();
        areset     = 1'b0;
        SM_writing = 1'b0;
        check_outs("midrst", mk(BASE + 32'h10, BASE, 1'b0, 1'b0, 16'd0, 16'd0));

        // Disable mid-frame clears progress and ignores pulses.
        do_reset(5'd2);
        pulses(2);
        SM_enable  = 1'b0;
        SM_writing = 1'b1;
        step();
        step();
        check("dis.write_buffer", SM_write_buffer, BASE + 32'h10);
        check("dis.frame_count",  SM_frame_count,  16'd0);
        SM_enable = 1'b1;
        pulses(3);
        check("dis.restart_frames", SM_frame_count, 16'd0);
        pulses(1);
        check("dis.restart_done",   SM_frame_count, 16'd1);

        // Length clamped to MAX_LOG_LENGTH: stride = 4 << 22.
        do_reset(5'd31);
        check("clamp.write_buffer", SM_write_buffer, BASE + 32'h0100_0000);

        // One-word frames: every pulse completes a frame.
        do_reset(5'd0);
        check("len0.write_buffer", SM_write_buffer, BASE + 32'h4);
        pulses(1);
        check("len0.frame_count",  SM_frame_count,  16'd1);
        check("len0.ready_valid",  SM_ready_valid,  1'b1);
        check("len0.next_write",   SM_write_buffer, BASE + 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
